// File: rtl/cpu_pkg.sv
// Shared constants and PC-source encoding for the ARM32 pipeline.
// Imported by the register file and its bypass mux.
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int PC_W_DEF   = 11;
    localparam int PC_IDX_DEF = 15;

    typedef enum logic [1:0] {
        PC_INC    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_START  = 2'b10,
        PC_HOLD   = 2'b11
    } pc_sel_e;

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port merge of stored data with same-cycle write data.
// Later (higher) write ports override earlier ones.
module regfile_bypass_mux
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = 4,
    parameter int NUM_WR = 2
) (
    input  logic [ADDR_W-1:0]        rd_addr_i,
    input  logic                     bypass_ok_i,
    input  logic [DATA_W-1:0]        stored_i,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     hit_o
);

    always_comb begin
        data_o = stored_i;
        hit_o  = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en_i[j] && wr_addr_i[j*ADDR_W +: ADDR_W] == rd_addr_i) begin
                hit_o = 1'b1;
                if (bypass_ok_i) begin
                    data_o = wr_data_i[j*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with aliased PC and load scoreboard.
// Produces combinational read data, busy flags and a stall request.
module regfile_mp
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 4,
    parameter int NUM_WR   = 2,
    parameter int PC_W     = PC_W_DEF,
    parameter int PC_IDX   = PC_IDX_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PC_W-1:0]          start_pc,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        rd_req,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     load_pc,
    input  logic [1:0]               sel_pc,
    input  logic [PC_W-1:0]          pc_in,
    output logic [PC_W-1:0]          pc,
    input  logic                     sb_set_en,
    input  logic [ADDR_W-1:0]        sb_set_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     stall,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
);

    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [NUM_REGS-1:0] sb_q, sb_d;
    logic                pc_wr;
    logic [PC_W-1:0]     pc_wval;
    logic [DATA_W-1:0]   pc_ext;

    function automatic logic in_rng(input logic [ADDR_W-1:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    assign pc_ext = DATA_W'(pc_q);
    assign pc     = pc_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] st;
        logic              ok;
        logic              hit;

        assign ra = rd_addr[i*ADDR_W +: ADDR_W];
        assign ok = in_rng(ra) && (ra != PC_A);
        assign st = !in_rng(ra)  ? '0 :
                    (ra == PC_A) ? pc_ext : regs_q[ra];

        regfile_bypass_mux #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR)
        ) u_mux (
            .rd_addr_i   (ra),
            .bypass_ok_i (ok),
            .stored_i    (st),
            .wr_en_i     (wr_en),
            .wr_addr_i   (wr_addr),
            .wr_data_i   (wr_data),
            .data_o      (rd_data[i*DATA_W +: DATA_W]),
            .hit_o       (hit)
        );

        // A same-cycle writeback is forwarded, so it clears the hazard.
        assign rd_busy[i] = in_rng(ra) && sb_q[ra] && !hit;
    end

    assign stall = |(rd_busy & rd_req);

    assign dbg_data = !in_rng(dbg_addr)  ? '0 :
                      (dbg_addr == PC_A) ? pc_ext : regs_q[dbg_addr];

    always_comb begin
        regs_d  = regs_q;
        sb_d    = sb_q;
        pc_wr   = 1'b0;
        pc_wval = pc_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && in_rng(wr_addr[j*ADDR_W +: ADDR_W])) begin
                if (wr_addr[j*ADDR_W +: ADDR_W] == PC_A) begin
                    pc_wr   = 1'b1;
                    pc_wval = wr_data[j*DATA_W +: PC_W];
                end else begin
                    regs_d[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*DATA_W +: DATA_W];
                end
                sb_d[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        // A newly issued load outranks a retiring one on the same register.
        if (sb_set_en && in_rng(sb_set_addr) && sb_set_addr != PC_A) begin
            sb_d[sb_set_addr] = 1'b1;
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (pc_wr) begin
            pc_d = pc_wval;
        end else if (load_pc) begin
            unique case (pc_sel_e'(sel_pc))
                PC_INC:    pc_d = pc_q + PC_W'(1);
                PC_BRANCH: pc_d = pc_in;
                PC_START:  pc_d = start_pc;
                PC_HOLD:   pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
            pc_q   <= start_pc;
            sb_q   <= '0;
        end else begin
            regs_q <= regs_d;
            pc_q   <= pc_d;
            sb_q   <= sb_d;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed table plus randomized model check for regfile_mp.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] start_pc;
    logic [15:0] rd_addr;
    logic [3:0]  rd_req;
    logic [127:0] rd_data;
    logic [1:0]  wr_en;
    logic [7:0]  wr_addr;
    logic [63:0] wr_data;
    logic        load_pc;
    logic [1:0]  sel_pc;
    logic [10:0] pc_in;
    logic [10:0] pc;
    logic        sb_set_en;
    logic [3:0]  sb_set_addr;
    logic [3:0]  rd_busy;
    logic        stall;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;

    logic [3:0]  ra [4];
    logic [3:0]  wa [2];
    logic [31:0] wd [2];

    assign rd_addr = {ra[3], ra[2], ra[1], ra[0]};
    assign wr_addr = {wa[1], wa[0]};
    assign wr_data = {wd[1], wd[0]};

    regfile_mp dut (
        .clk         (clk),
        .rst         (rst),
        .start_pc    (start_pc),
        .rd_addr     (rd_addr),
        .rd_req      (rd_req),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .load_pc     (load_pc),
        .sel_pc      (sel_pc),
        .pc_in       (pc_in),
        .pc          (pc),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .rd_busy     (rd_busy),
        .stall       (stall),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  wen;
        logic [3:0]  wa0;
        logic [31:0] wd0;
        logic [3:0]  wa1;
        logic [31:0] wd1;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic [3:0]  rq;
        logic        sbs;
        logic [3:0]  sba;
        logic        lpc;
        logic [1:0]  sel;
        logic [10:0] pcin;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [3:0]  ebusy;
        logic        estall;
        logic [10:0] epc;
    } vec_t;

    function automatic vec_t mk(
        int r, int wen, int wa0, int wd0, int wa1, int wd1,
        int ra0, int ra1, int rq, int sbs, int sba,
        int lpc, int sel, int pcin,
        int e0, int e1, int eb, int es, int epc);
        vec_t v;
        v.rst = 1'(r);      v.wen = 2'(wen);
        v.wa0 = 4'(wa0);    v.wd0 = 32'(wd0);
        v.wa1 = 4'(wa1);    v.wd1 = 32'(wd1);
        v.ra0 = 4'(ra0);    v.ra1 = 4'(ra1);
        v.rq = 4'(rq);      v.sbs = 1'(sbs);
        v.sba = 4'(sba);    v.lpc = 1'(lpc);
        v.sel = 2'(sel);    v.pcin = 11'(pcin);
        v.e0 = 32'(e0);     v.e1 = 32'(e1);
        v.ebusy = 4'(eb);   v.estall = 1'(es);
        v.epc = 11'(epc);
        return v;
    endfunction

    // Behavioural reference state
    logic [31:0] mregs [16];
    logic [10:0] mpc;
    logic [15:0] msb;

    function automatic logic [31:0] m_rd(input logic [3:0] a);
        logic [31:0] v;
        if (a == 4'd15) return {21'b0, mpc};
        v = mregs[a];
        for (int j = 0; j < 2; j++)
            if (wr_en[j] && wa[j] == a) v = wd[j];
        return v;
    endfunction

    function automatic logic m_busy(input logic [3:0] a);
        logic w;
        w = 1'b0;
        for (int j = 0; j < 2; j++)
            if (wr_en[j] && wa[j] == a) w = 1'b1;
        return msb[a] && !w;
    endfunction

    task automatic m_edge();
        logic        pcw;
        logic [10:0] pv;
        pcw = 1'b0;
        pv  = '0;
        if (rst) begin
            for (int k = 0; k < 16; k++) mregs[k] = '0;
            mpc = start_pc;
            msb = '0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (wr_en[j]) begin
                    if (wa[j] == 4'd15) begin
                        pcw = 1'b1;
                        pv  = wd[j][10:0];
                    end else begin
                        mregs[wa[j]] = wd[j];
                    end
                    msb[wa[j]] = 1'b0;
                end
            end
            if (sb_set_en && sb_set_addr != 4'd15) msb[sb_set_addr] = 1'b1;
            if (pcw) mpc = pv;
            else if (load_pc) begin
                case (sel_pc)
                    2'd0: mpc = 11'((int'(mpc) + 1) % 2048);
                    2'd1: mpc = pc_in;
                    2'd2: mpc = start_pc;
                    default: mpc = mpc;
                endcase
            end
        end
    endtask

    function automatic logic [3:0] pick();
        if ($urandom_range(0, 4) == 0) return 4'd15;
        return 4'($urandom_range(0, 5));
    endfunction

    vec_t tbl [19];

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = mk(0,0,0,0,0,0,        3,0,0, 0,0, 1,0,0, 0,0,0,0,100);
        tbl[1]  = mk(0,0,0,0,0,0,        3,0,0, 0,0, 1,0,0, 0,0,0,0,101);
        tbl[2]  = mk(0,0,0,0,0,0,        3,0,0, 0,0, 1,0,0, 0,0,0,0,102);
        tbl[3]  = mk(0,3,3,'hAAAA,3,'hBBBB, 3,0,0, 0,0, 0,0,0, 'hBBBB,0,0,0,103);
        tbl[4]  = mk(0,0,0,0,0,0,        3,0,0, 0,0, 0,0,0, 'hBBBB,0,0,0,103);
        tbl[5]  = mk(0,1,15,'h1234,0,0,  15,0,0, 0,0, 1,1,5, 103,0,0,0,103);
        tbl[6]  = mk(0,0,0,0,0,0,        15,0,0, 0,0, 0,0,0, 'h234,0,0,0,'h234);
        tbl[7]  = mk(0,0,0,0,0,0,        0,7,2, 1,7, 0,0,0, 0,0,0,0,'h234);
        tbl[8]  = mk(0,0,0,0,0,0,        0,7,2, 0,0, 0,0,0, 0,0,2,1,'h234);
        tbl[9]  = mk(0,2,0,0,7,'h55,     0,7,2, 0,0, 0,0,0, 0,'h55,0,0,'h234);
        tbl[10] = mk(0,0,0,0,0,0,        0,7,2, 0,0, 0,0,0, 0,'h55,0,0,'h234);
        tbl[11] = mk(0,1,2,'h22,0,0,     2,0,1, 1,2, 0,0,0, 'h22,0,0,0,'h234);
        tbl[12] = mk(0,0,0,0,0,0,        2,0,1, 0,0, 0,0,0, 'h22,0,1,1,'h234);
        tbl[13] = mk(0,0,0,0,0,0,        2,0,0, 0,0, 0,0,0, 'h22,0,1,0,'h234);
        tbl[14] = mk(0,1,15,'h7FF,0,0,   15,0,0, 0,0, 0,0,0, 'h234,0,0,0,'h234);
        tbl[15] = mk(0,0,0,0,0,0,        15,0,0, 0,0, 1,0,0, 'h7FF,0,0,0,'h7FF);
        tbl[16] = mk(0,0,0,0,0,0,        15,0,0, 0,0, 0,0,0, 0,0,0,0,0);
        tbl[17] = mk(1,1,4,'h44,0,0,     4,0,0, 1,4, 0,0,0, 'h44,0,0,0,0);
        tbl[18] = mk(0,0,0,0,0,0,        4,2,3, 0,0, 0,0,0, 0,0,0,0,100);

        rst = 1'b1;  start_pc = 11'd100;
        rd_req = '0; wr_en = '0;
        load_pc = 1'b0; sel_pc = '0; pc_in = '0;
        sb_set_en = 1'b0; sb_set_addr = '0; dbg_addr = '0;
        for (int k = 0; k < 4; k++) ra[k] = '0;
        for (int k = 0; k < 2; k++) begin wa[k] = '0; wd[k] = '0; end

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset sweep: every non-PC register reads zero, nothing busy
        for (int a = 0; a < 15; a++) begin
            for (int k = 0; k < 4; k++) ra[k] = 4'(a);
            dbg_addr = 4'(a);
            rd_req   = 4'hF;
            @(negedge clk);
            for (int k = 0; k < 4; k++)
                chk($sformatf("rst.rd%0d.r%0d", k, a), rd_data[k*32 +: 32], 32'd0);
            chk($sformatf("rst.dbg.r%0d", a), dbg_data, 32'd0);
            chk("rst.stall", {31'b0, stall}, 32'd0);
            chk("rst.pc", {21'b0, pc}, 32'd100);
            @(posedge clk);
            #1;
        end
        rd_req = '0;
        dbg_addr = '0;

        for (int i = 0; i < 19; i++) begin
            rst = tbl[i].rst;
            wr_en = tbl[i].wen;
            wa[0] = tbl[i].wa0; wd[0] = tbl[i].wd0;
            wa[1] = tbl[i].wa1; wd[1] = tbl[i].wd1;
            ra[0] = tbl[i].ra0; ra[1] = tbl[i].ra1;
            ra[2] = 4'd3;       ra[3] = 4'd3;
            rd_req = tbl[i].rq;
            sb_set_en = tbl[i].sbs; sb_set_addr = tbl[i].sba;
            load_pc = tbl[i].lpc; sel_pc = tbl[i].sel; pc_in = tbl[i].pcin;
            @(negedge clk);
            chk($sformatf("v%0d.rd0", i), rd_data[31:0], tbl[i].e0);
            chk($sformatf("v%0d.rd1", i), rd_data[63:32], tbl[i].e1);
            chk($sformatf("v%0d.busy", i), {28'b0, rd_busy}, {28'b0, tbl[i].ebusy});
            chk($sformatf("v%0d.stall", i), {31'b0, stall}, {31'b0, tbl[i].estall});
            chk($sformatf("v%0d.pc", i), {21'b0, pc}, {21'b0, tbl[i].epc});
            @(posedge clk);
            #1;
        end

        for (int k = 0; k < 16; k++) mregs[k] = '0;
        mpc = 11'd100;
        msb = '0;

        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0) start_pc = 11'($urandom);
            wr_en = 2'($urandom);
            for (int j = 0; j < 2; j++) begin
                wa[j] = pick();
                wd[j] = $urandom;
            end
            for (int k = 0; k < 4; k++) ra[k] = pick();
            rd_req = 4'($urandom);
            sb_set_en = 1'($urandom);
            sb_set_addr = pick();
            load_pc = 1'($urandom);
            sel_pc = 2'($urandom);
            pc_in = 11'($urandom);
            dbg_addr = 4'($urandom);
            @(negedge clk);
            begin
                logic [3:0] eb;
                logic       es;
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("rnd%0d.rd%0d", c, k), rd_data[k*32 +: 32], m_rd(ra[k]));
                    eb[k] = m_busy(ra[k]);
                end
                es = |(eb & rd_req);
                chk($sformatf("rnd%0d.busy", c), {28'b0, rd_busy}, {28'b0, eb});
                chk($sformatf("rnd%0d.stall", c), {31'b0, stall}, {31'b0, es});
                chk($sformatf("rnd%0d.pc", c), {21'b0, pc}, {21'b0, mpc});
                chk($sformatf("rnd%0d.dbg", c), dbg_data,
                    (dbg_addr == 4'd15) ? {21'b0, mpc} : mregs[dbg_addr]);
            end
            @(posedge clk);
            m_edge();
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file with an integrated PC register and a load scoreboard, for the pipelined ARM32 core.
- Generalises the core's fixed register set in four ways:
  - configurable count of read ports (operand, shift, store, debug) and write ports (ALU result, LDR writeback);
  - same-cycle write-through bypass;
  - deterministic write-conflict priority;
  - per-register pending-load tracking, which produces a stall request for the controller.

Parameters:
- DATA_W, 32, register width.
- NUM_REGS, 16, architectural register count.
- ADDR_W, $clog2(NUM_REGS), register address width.
- NUM_RD, 4, read ports.
- NUM_WR, 2, write ports; a higher index has higher priority.
- PC_W, 11, PC width.
- PC_IDX, 15, register index aliased to the PC.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start_pc  in  PC_W  PC value loaded at reset.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i is bits [i*ADDR_W +: ADDR_W].
- rd_req  in  NUM_RD  read port i is in use this cycle.
- rd_data  out  NUM_RD*DATA_W  packed read data.
- wr_en  in  NUM_WR  write enables.
- wr_addr  in  NUM_WR*ADDR_W  packed write addresses.
- wr_data  in  NUM_WR*DATA_W  packed write data.
- load_pc  in  1  update the PC this cycle.
- sel_pc  in  2  PC source: 00 pc+1, 01 pc_in, 10 start_pc, 11 hold.
- pc_in  in  PC_W  branch target.
- pc  out  PC_W  current PC.
- sb_set_en  in  1  mark a register pending (an LDR has been issued).
- sb_set_addr  in  ADDR_W  register to mark pending.
- rd_busy  out  NUM_RD  the register read on port i is pending.
- stall  out  1  OR over i of (rd_busy[i] & rd_req[i]).
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  debug read data; no bypass applied.

Behaviour:
- Reset (rst=1 at a clk edge):
  - all registers become 0;
  - pc becomes start_pc;
  - all scoreboard bits are cleared;
  - rst overrides every write, load_pc and sb_set_en in that cycle.
- Outputs after reset: rd_data equals bypass data or 0; rd_busy=0; stall=0; dbg_data=0.
- Reads are combinational with zero latency.
  - A read of a non-PC register returns the register contents, unless some wr_en[j] is set with wr_addr[j]==rd_addr[i]. In that case it returns wr_data of the highest such j (write-through bypass).
  - A read of PC_IDX returns {zero-extension of pc}; no bypass applies.
- Writes take effect at the clk edge.
  - When several ports write the same address in one cycle, the highest port index wins.
  - Writes to PC_IDX do not touch register storage. They set pc to wr_data[PC_W-1:0] of the winning port.
  - A write to PC_IDX has priority over load_pc.
- PC update: if load_pc=1 and no write targets PC_IDX, pc updates per sel_pc.
  - pc+1 wraps modulo 2^PC_W (for example 2047 goes to 0).
  - sel_pc=11 holds pc.
- Scoreboard (NUM_REGS bits):
  - any write, on any port, to register r clears bit r at the edge;
  - sb_set_en sets bit sb_set_addr;
  - if a set and a clear target the same r in the same cycle, the set wins (a new load has been issued);
  - sb_set_en to PC_IDX is ignored.
- rd_busy[i] = sb[rd_addr[i]] AND NOT (a write to rd_addr[i] this cycle). A same-cycle writeback resolves the hazard through the bypass.
- stall is combinational.
- NUM_RD and NUM_WR must be at least 1.
- Addresses ≥ NUM_REGS, possible when NUM_REGS is not a power of two:
  - reads return 0;
  - writes and sb_set_en are ignored.

Decomposition:
- Package cpu_pkg holds:
  - the PC_IDX default;
  - an enum pc_sel_e with values PC_INC, PC_BRANCH, PC_START, PC_HOLD;
  - the default DATA_W and PC_W constants.
- One sub-module, regfile_bypass_mux: per read port, it combines stored data with the write-port bypass using a priority-select loop.
- The scoreboard and PC logic live in regfile_mp.

Test Plan:
1. Reset behaviour: rst=1 with start_pc=11'd100, then release → pc=100; every read returns 0; stall=0. Then load_pc=1, sel_pc=00 for 3 cycles → pc=103.
2. Write conflict and bypass: wr_en=2'b11, both ports writing r3 with 0xAAAA and 0xBBBB, while rd_addr[0]=3 → rd_data[0]=0xBBBB in the same cycle. The next cycle, with wr_en=0, rd_data[0] is still 0xBBBB.
3. PC write over load_pc: port 0 writes r15 with 0x1234 while load_pc=1, sel_pc=01, pc_in=5 → next pc=0x234 (the 11-bit slice). A read of r15 returns 0x00000234.
4. Scoreboard stall: sb_set_en for r7. Next cycle rd_addr[1]=7, rd_req[1]=1 → rd_busy[1]=1, stall=1. The cycle after, port 1 writes r7=0x55 → rd_busy[1]=0, stall=0, rd_data[1]=0x55 (bypass).
5. Set/clear collision: sb_set_en for r2 and wr_en for r2 in the same cycle → bit 2 remains set, so a later read of r2 with rd_req stalls.
6. Wrap and reset mid-operation: pc=2047 with load_pc=1, sel_pc=00 → pc=0. Then assert rst in the same cycle as a write to r4 and sb_set_en for r4 → r4=0 and no register is busy.
